mult_acc_pipe: RTL and testbench
================================

# mult_acc_pipe

Pipelined, multi-lane signed fixed-point multiplier with round-half-up rescaling and an optional per-lane accumulate mode. It serves the LSTM gate datapath in two ways. It can act as a registered, back-pressurable drop-in for the plain two-input multiplier, or it can compute dot-product partial sums (weight × input summed over a burst) without an external adder. Each lane keeps the existing WIDTH/FRAC Q-format, so its outputs feed directly into the current activation and adder blocks.

## Interface
- WIDTH, 24: operand, result and accumulator width (signed, two's complement).
- FRAC, 16: fractional bits; product rescaled by 2^-FRAC.
- LANES, 1: independent parallel lanes sharing one handshake.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat this cycle.
- i_a, i_b  in  LANES*WIDTH  operands; lane k at [k*WIDTH +: WIDTH].
- i_acc  in  1  beat belongs to an accumulation burst.
- i_clr  in  1  with i_acc: first beat of a burst, so the accumulator loads instead of adding.
- i_last  in  1  with i_acc: final beat of a burst; the sum is emitted.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output.
- o_data  out  LANES*WIDTH  results, same lane packing as the inputs.
- o_ovf  out  LANES  per-lane overflow flag for this output beat.

## Operation
- Input transfer happens when i_valid && o_ready. Output transfer happens when o_valid && i_ready.
- Pipeline enable is en = !o_valid || i_ready. o_ready = en. The whole pipeline stalls together.
- S1 (on en):
  - s1_v <= i_valid.
  - Register the full 2*WIDTH signed product per lane, plus i_acc, i_clr and i_last.
- S2 (on en):
  - Rounded value per lane: r = prod[FRAC+WIDTH-1:FRAC] + prod[FRAC-1] (round half up, toward +inf on ties).
  - Non-accumulate beat (s1_v && !acc): o_data <= r; o_valid <= 1.
  - Accumulate beat: acc <= (clr ? 0 : acc) + r.
    - If last: o_data <= the new sum, o_valid <= 1, and the accumulator is cleared to 0.
    - Otherwise the accumulator updates and o_valid <= 0.
  - Bubble (!s1_v): o_valid <= 0. The accumulator is unchanged.
- An accumulate beat without i_clr adds to the current accumulator. A burst that starts without i_clr therefore continues from 0 (after reset or the last i_last) or from the partial sum.
- A beat with i_clr && i_last together is a one-beat burst: the output equals r.
- A non-accumulate beat issued mid-burst passes through and leaves the accumulator untouched.
- Without MULT_SAT_EN, all sums and rescaling wrap modulo 2^WIDTH.
- Reset values: o_valid=0, o_data=0, o_ovf=0, s1_v=0, accumulators=0. o_ready is 1 one cycle after reset release. Reset mid-burst discards the partial sums.

## Timing
- Latency is 2 cycles: a beat accepted at edge N produces o_valid at edge N+2 (if no stall).
- Throughput is 1 beat/cycle. A burst of L beats yields one output 2 cycles after its last beat.
- With o_valid && !i_ready:
  - o_data, o_ovf, the S1 registers and the accumulators hold.
  - o_ready=0, so no input is consumed.
- o_ready is combinational from o_valid and i_ready only; it never depends on i_valid.

## Configuration
- MULT_SAT_EN defined:
  - Overflow check: the rescaled product and every accumulator sum are checked against [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Clamping: an out-of-range value is clamped to the nearest limit.
  - Flagging: o_ovf[k] is set for that output beat if any clamp occurred in lane k during the beat or its burst. This uses a per-lane sticky bit that is cleared on clr/last/reset.
  - The rounding increment is included in the range check.
- MULT_SAT_EN undefined: wrap-around arithmetic, o_ovf tied to 0, no sticky logic synthesised.

## Structure
- Shared package/header mult_pkg:
  - Default WIDTH/FRAC.
  - A function returning the Q-format min/max constants.
  - Lane slice helpers.
- One sub-module, fx_round_sat (combinational): takes a signed input of width 2*WIDTH, or WIDTH+1 for the accumulator sum, and returns a WIDTH result plus an ovf bit. It is instantiated per lane for the product path and for the accumulator path. Its saturation logic is under MULT_SAT_EN.

## Test plan
1. Single lane, WIDTH=24, FRAC=16: a=0x018000 (1.5), b=0x020000 (2.0), no acc -> o_data=0x030000 two cycles later, o_ovf=0.
2. Rounding:
   - a=0x000001, b=0x008000 -> o_data=0x000001.
   - a=0xFFFFFF, b=0x008000 -> o_data=0x000000.
3. Accumulate: 4 beats of a=0x010000, b=0x008000; clr on beat 1, last on beat 4 -> exactly one output, 0x020000, 2 cycles after beat 4. No o_valid during beats 1-3.
4. Overflow: a=b=0x7FFFFF -> 0x7FFFFF with o_ovf=1 if MULT_SAT_EN is defined; 0xFFFF00 with o_ovf=0 otherwise.
5. Backpressure: i_ready low for 5 cycles with continuous i_valid -> o_data stable, o_ready=0, no beat lost or duplicated after release. Check the sequence against the reference model.
6. Reset: assert i_rst_n low after beat 2 of a burst -> o_valid=0 immediately. A new burst without clr starts from 0. LANES=4 with distinct per-lane operands checks lane packing.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared Q-format defaults, range limits and lane slicing helpers for mult_acc_pipe.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 24;
  localparam int DEFAULT_FRAC  = 16;

  typedef struct packed {
    logic signed [63:0] minVal;
    logic signed [63:0] maxVal;
  } qLimits_t;

  // Representable range of a signed WIDTH-bit two's complement value.
  function automatic qLimits_t qLimits(input int width);
    qLimits_t lim;
    lim.maxVal = (64'sd1 <<< (width - 1)) - 64'sd1;
    lim.minVal = -(64'sd1 <<< (width - 1));
    return lim;
  endfunction

  function automatic int laneLo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Rescales a signed value by 2^-SHIFT with round-half-up and narrows it to WIDTH bits.
// With MULT_SAT_EN defined the result clamps to the Q-format range and flags ovf; otherwise it wraps.
module fx_round_sat
  import mult_pkg::*;
#(
  parameter int IN_W  = 48,
  parameter int WIDTH = 24,
  parameter int SHIFT = 16
) (
  input  logic signed [IN_W-1:0]  x_i,
  output logic        [WIDTH-1:0] y_o,
  output logic                    ovf_o
);

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] scaled;

  assign ext = {x_i[IN_W-1], x_i};

  // One guard bit keeps the rounding increment from wrapping before the range check.
  if (SHIFT > 0) begin : g_rnd
    assign scaled = (ext >>> SHIFT) + $signed({{IN_W{1'b0}}, x_i[SHIFT-1]});
  end else begin : g_pass
    assign scaled = ext;
  end

`ifdef MULT_SAT_EN
  localparam qLimits_t LIM = qLimits(WIDTH);

  logic signed [63:0] wide;

  assign wide = 64'(scaled);

  always_comb begin
    y_o   = scaled[WIDTH-1:0];
    ovf_o = 1'b0;
    if (wide > $signed(LIM.maxVal)) begin
      y_o   = LIM.maxVal[WIDTH-1:0];
      ovf_o = 1'b1;
    end else if (wide < $signed(LIM.minVal)) begin
      y_o   = LIM.minVal[WIDTH-1:0];
      ovf_o = 1'b1;
    end
  end
`else
  logic unusedHigh;

  assign unusedHigh = ^scaled[IN_W:WIDTH];
  assign y_o        = scaled[WIDTH-1:0];
  assign ovf_o      = 1'b0;
`endif

endmodule

// File: rtl/mult_acc_pipe.sv
// Two-stage pipelined multi-lane signed Q-format multiplier with optional per-lane accumulation.
// Define MULT_SAT_EN for saturating arithmetic with sticky per-lane overflow flags; default wraps.
module mult_acc_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int FRAC  = DEFAULT_FRAC,
  parameter int LANES = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES*WIDTH-1:0] i_a,
  input  logic [LANES*WIDTH-1:0] i_b,
  input  logic                   i_acc,
  input  logic                   i_clr,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic [LANES-1:0]       o_ovf
);

  localparam int PW = 2 * WIDTH;

  logic en;
  logic outFire;
  logic s1Valid_q, accMode_q, clr_q, last_q;
  logic oValid_q;
  logic [LANES-1:0][PW-1:0]    prod_q, prod_d;
  logic [LANES-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [LANES-1:0][WIDTH-1:0] oData_q, oData_d;
`ifdef MULT_SAT_EN
  logic [LANES-1:0] sticky_q, sticky_d;
  logic [LANES-1:0] oOvf_q, oOvf_d;
`endif

  // The whole pipeline advances together whenever the output register is free to change.
  assign en      = !oValid_q || i_ready;
  assign o_ready = en;
  assign outFire = s1Valid_q && (!accMode_q || last_q);
  assign o_valid = oValid_q;
  assign o_data  = oData_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [PW-1:0] aExt, bExt;
    logic [WIDTH-1:0] rnd, base, sum;
    logic [WIDTH:0]   sumIn;
    logic             rndOvf, sumOvf;

    assign aExt      = PW'($signed(i_a[laneLo(k, WIDTH) +: WIDTH]));
    assign bExt      = PW'($signed(i_b[laneLo(k, WIDTH) +: WIDTH]));
    assign prod_d[k] = aExt * bExt;

    fx_round_sat #(.IN_W(PW), .WIDTH(WIDTH), .SHIFT(FRAC)) u_prodRnd (
      .x_i   ($signed(prod_q[k])),
      .y_o   (rnd),
      .ovf_o (rndOvf)
    );

    assign base  = clr_q ? '0 : acc_q[k];
    assign sumIn = {base[WIDTH-1], base} + {rnd[WIDTH-1], rnd};

    fx_round_sat #(.IN_W(WIDTH + 1), .WIDTH(WIDTH), .SHIFT(0)) u_accSat (
      .x_i   ($signed(sumIn)),
      .y_o   (sum),
      .ovf_o (sumOvf)
    );

    assign acc_d[k]   = (s1Valid_q && accMode_q) ? (last_q ? '0 : sum) : acc_q[k];
    assign oData_d[k] = outFire ? (accMode_q ? sum : rnd) : oData_q[k];

`ifdef MULT_SAT_EN
    logic stickyNew;

    assign stickyNew   = (clr_q ? 1'b0 : sticky_q[k]) | rndOvf | sumOvf;
    assign sticky_d[k] = (s1Valid_q && accMode_q) ? (last_q ? 1'b0 : stickyNew) : sticky_q[k];
    assign oOvf_d[k]   = outFire ? (accMode_q ? stickyNew : rndOvf) : oOvf_q[k];
`else
    logic unusedOvf;

    assign unusedOvf = rndOvf | sumOvf;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1Valid_q <= 1'b0;
      accMode_q <= 1'b0;
      clr_q     <= 1'b0;
      last_q    <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      oData_q   <= '0;
      oValid_q  <= 1'b0;
    end else if (en) begin
      s1Valid_q <= i_valid;
      accMode_q <= i_acc;
      clr_q     <= i_clr;
      last_q    <= i_last;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      oData_q   <= oData_d;
      oValid_q  <= outFire;
    end
  end

`ifdef MULT_SAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_q <= '0;
      oOvf_q   <= '0;
    end else if (en) begin
      sticky_q <= sticky_d;
      oOvf_q   <= oOvf_d;
    end
  end

  assign o_ovf = oOvf_q;
`else
  assign o_ovf = '0;
`endif

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Directed self-checking bench for mult_acc_pipe with four lanes of 24-bit Q8.16 data.
// Overflow expectations follow MULT_SAT_EN when the bench is built with it.
module tb_mult_acc_pipe;

  localparam int WIDTH = 24;
  localparam int FRAC  = 16;
  localparam int LANES = 4;
  localparam int DW    = WIDTH * LANES;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_a;
  logic [DW-1:0] i_b;
  logic          i_acc;
  logic          i_clr;
  logic          i_last;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [LANES-1:0] o_ovf;

  int checks = 0;
  int errors = 0;

  mult_acc_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .LANES(LANES)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_acc   (i_acc),
    .i_clr   (i_clr),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_ovf   (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DW-1:0] pk(input logic [WIDTH-1:0] l3, input logic [WIDTH-1:0] l2,
                                       input logic [WIDTH-1:0] l1, input logic [WIDTH-1:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [DW-1:0] bpA(input int k);
    logic [WIDTH-1:0] v;
    v = WIDTH'((k + 1) * 65536);
    return pk(v, v, v, v);
  endfunction

  // Lane l multiplies (k+1).0 by (l+1).0, so the exact product is an integer in Q-format.
  function automatic logic [DW-1:0] bpExp(input int k);
    return pk(WIDTH'((k + 1) * 4 * 65536), WIDTH'((k + 1) * 3 * 65536),
              WIDTH'((k + 1) * 2 * 65536), WIDTH'((k + 1) * 65536));
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic valid, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic acc, input logic clr, input logic last);
    i_valid = valid;
    i_a     = a;
    i_b     = b;
    i_acc   = acc;
    i_clr   = clr;
    i_last  = last;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] laneA, b1, b2, b3;
    logic [LANES-1:0] ovfExp;
    logic [DW-1:0] ovfData;
    int nextIn, nextOut;
    logic inAcc, outAcc;

    laneA = pk(24'h040000, 24'h030000, 24'h020000, 24'h010000);
    b1    = pk(24'h010000, 24'h010000, 24'h010000, 24'h010000);
    b2    = pk(24'h020000, 24'h020000, 24'h020000, 24'h020000);
    b3    = pk(24'h030000, 24'h030000, 24'h030000, 24'h030000);

    i_rst_n = 1'b0;
    i_ready = 1'b1;
    idle();
    tick();
    tick();
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_data", o_data, 0);
    checkOutput("rst_ovf", o_ovf, 0);
    i_rst_n = 1'b1;
    tick();
    checkOutput("rst_ready", o_ready, 1);

    // 1.5 * 2.0 on lane 0
    applyStimulus(1'b1, pk(0, 0, 0, 24'h018000), pk(0, 0, 0, 24'h020000), 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("t1_one_edge", o_valid, 0);
    tick();
    checkOutput("t1_valid", o_valid, 1);
    checkOutput("t1_data", o_data, pk(0, 0, 0, 24'h030000));
    checkOutput("t1_ovf", o_ovf, 0);

    applyStimulus(1'b1, pk(0, 0, 0, 24'h000001), pk(0, 0, 0, 24'h008000), 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, pk(0, 0, 0, 24'hFFFFFF), pk(0, 0, 0, 24'h008000), 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("t2_pos_half_valid", o_valid, 1);
    checkOutput("t2_pos_half", o_data, pk(0, 0, 0, 24'h000001));
    tick();
    checkOutput("t2_neg_half_valid", o_valid, 1);
    checkOutput("t2_neg_half", o_data, pk(0, 0, 0, 24'h000000));
    tick();
    checkOutput("t2_drain", o_valid, 0);

    // four 1.0 * 0.5 beats accumulate to 2.0 with a single output
    applyStimulus(1'b1, pk(0, 0, 0, 24'h010000), pk(0, 0, 0, 24'h008000), 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("t3_beat1", o_valid, 0);
    applyStimulus(1'b1, pk(0, 0, 0, 24'h010000), pk(0, 0, 0, 24'h008000), 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("t3_beat2", o_valid, 0);
    tick();
    checkOutput("t3_beat3", o_valid, 0);
    applyStimulus(1'b1, pk(0, 0, 0, 24'h010000), pk(0, 0, 0, 24'h008000), 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    checkOutput("t3_beat4", o_valid, 0);
    tick();
    checkOutput("t3_sum_valid", o_valid, 1);
    checkOutput("t3_sum", o_data, pk(0, 0, 0, 24'h020000));
    tick();
    checkOutput("t3_single_out", o_valid, 0);

`ifdef MULT_SAT_EN
    ovfData = pk(0, 0, 0, 24'h7FFFFF);
    ovfExp  = 4'b0001;
`else
    ovfData = pk(0, 0, 0, 24'hFFFF00);
    ovfExp  = 4'b0000;
`endif
    applyStimulus(1'b1, pk(0, 0, 0, 24'h7FFFFF), pk(0, 0, 0, 24'h7FFFFF), 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("t4_valid", o_valid, 1);
    checkOutput("t4_data", o_data, ovfData);
    checkOutput("t4_ovf", o_ovf, ovfExp);
    tick();

    // continuous input with the consumer stalled for cycles 3..7
    nextIn  = 0;
    nextOut = 0;
    for (int cyc = 0; cyc < 60 && nextOut < 8; cyc++) begin
      i_ready = !(cyc >= 3 && cyc <= 7);
      if (nextIn < 8) applyStimulus(1'b1, bpA(nextIn), laneA, 1'b0, 1'b0, 1'b0);
      else idle();
      #1;
      if (cyc >= 3 && cyc <= 7) begin
        checkOutput("t5_stall_ready", o_ready, 0);
        checkOutput("t5_stall_valid", o_valid, 1);
      end
      if (o_valid) checkOutput($sformatf("t5_data%0d", nextOut), o_data, bpExp(nextOut));
      inAcc  = i_valid && o_ready;
      outAcc = o_valid && i_ready;
      tick();
      if (inAcc) nextIn++;
      if (outAcc) nextOut++;
    end
    i_ready = 1'b1;
    idle();
    checkOutput("t5_out_count", nextOut, 8);
    checkOutput("t5_in_count", nextIn, 8);
    tick();
    checkOutput("t5_no_extra", o_valid, 0);

    // reset mid-burst discards the partial sums on all lanes
    applyStimulus(1'b1, laneA, b1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, laneA, b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, laneA, b2, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("t6_partial_hidden", o_valid, 0);
    tick();
    checkOutput("t6_pass_valid", o_valid, 1);
    checkOutput("t6_pass_data", o_data, pk(24'h080000, 24'h060000, 24'h040000, 24'h020000));
    i_rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", o_valid, 0);
    checkOutput("t6_rst_data", o_data, 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, laneA, b3, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    checkOutput("t6_fresh_valid", o_valid, 1);
    checkOutput("t6_fresh_sum", o_data, pk(24'h0C0000, 24'h090000, 24'h060000, 24'h030000));
    tick();

    // a plain beat inside a burst passes through without touching the accumulator
    applyStimulus(1'b1, laneA, b1, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, laneA, b2, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, laneA, b3, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    checkOutput("t7_pass_data", o_data, pk(24'h080000, 24'h060000, 24'h040000, 24'h020000));
    tick();
    checkOutput("t7_sum_valid", o_valid, 1);
    checkOutput("t7_sum", o_data, pk(24'h100000, 24'h0C0000, 24'h080000, 24'h040000));
    tick();

    // clr together with last restarts from zero even over a pending partial sum
    applyStimulus(1'b1, laneA, b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, laneA, b2, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    checkOutput("t8_partial_hidden", o_valid, 0);
    tick();
    checkOutput("t8_one_beat_valid", o_valid, 1);
    checkOutput("t8_one_beat", o_data, pk(24'h080000, 24'h060000, 24'h040000, 24'h020000));
    tick();
    checkOutput("t8_drain", o_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
